lif_timestep_neuron: RTL

Leaky integrate-and-fire neuron that consumes the per-timestep `clear` and `set` pulses from the timestep control generator. The neuron accumulates weighted input spikes during a timestep and zeroes its accumulator on each `clear` rising edge. On each `set` rising edge it applies leak, integrates the accumulated input into the membrane potential, compares against threshold, and emits a one-cycle output spike. It sits downstream of the timestep generator in each neuron tile, one instance per neuron.

---
 rtl/lif_timestep_neuron.sv | 111 +++++++++++
 1 files changed

// File: rtl/lif_timestep_neuron.sv
// Leaky integrate-and-fire neuron driven by per-timestep clear/set pulses.
// Optional leak in EVAL is compiled in when NEURON_LEAK_EN is defined.
module lif_timestep_neuron #(
   parameter int                      WEIGHT_W   = 16,
   parameter int                      POT_W      = 24,
   parameter logic signed [POT_W-1:0] THRESH     = 24'sd1000,
   parameter logic signed [POT_W-1:0] V_RESET    = '0,
   parameter int                      LEAK_SHIFT = 3
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic                clear,
   input  logic                set,
   input  logic                in_valid,
   input  logic [WEIGHT_W-1:0] in_weight,
   output logic                spike_out,
   output logic [POT_W-1:0]    potential,
   output logic [31:0]         timestep,
   output logic                overrun
);

   if (POT_W <= WEIGHT_W || LEAK_SHIFT < 0 || LEAK_SHIFT >= POT_W) begin : g_bad_param
      $error("lif_timestep_neuron: illegal WEIGHT_W/POT_W/LEAK_SHIFT");
   end

   typedef enum logic [1:0] {S_ACCUM, S_EVAL, S_EMIT} state_t;

   localparam logic signed [POT_W-1:0] POT_MAX = {1'b0, {(POT_W-1){1'b1}}};
   localparam logic signed [POT_W-1:0] POT_MIN = {1'b1, {(POT_W-1){1'b0}}};

   state_t                   state_q;
   logic                     clear_dly_q, set_dly_q;
   logic signed [POT_W-1:0]  acc_q, snap_q, pot_q;
   logic [31:0]              ts_q;
   logic                     spike_q, overrun_q;

   logic                     clear_edge, set_edge;
   logic signed [POT_W-1:0]  acc_base, acc_d;
   logic signed [POT_W:0]    w_ext, acc_sum, eval_sum;

   // Collapse a POT_W+1 result back into POT_W with clamping at the signed limits.
   function automatic logic signed [POT_W-1:0] sat(input logic signed [POT_W:0] v);
      if (v[POT_W] != v[POT_W-1]) return v[POT_W] ? POT_MIN : POT_MAX;
      return v[POT_W-1:0];
   endfunction

   assign clear_edge = clear & ~clear_dly_q;
   assign set_edge   = set & ~set_dly_q;

   always_comb begin
      w_ext    = {{(POT_W+1-WEIGHT_W){in_weight[WEIGHT_W-1]}}, in_weight};
      // A clear edge wins over the held value; a same-cycle input lands on top of zero.
      acc_base = clear_edge ? '0 : acc_q;
      acc_sum  = {acc_base[POT_W-1], acc_base} + w_ext;
      acc_d    = in_valid ? sat(acc_sum) : acc_base;
`ifdef NEURON_LEAK_EN
      eval_sum = {pot_q[POT_W-1], pot_q}
               - {pot_q[POT_W-1], (pot_q >>> LEAK_SHIFT)}
               + {snap_q[POT_W-1], snap_q};
`else
      eval_sum = {pot_q[POT_W-1], pot_q} + {snap_q[POT_W-1], snap_q};
`endif
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q     <= S_ACCUM;
         clear_dly_q <= 1'b0;
         set_dly_q   <= 1'b0;
         acc_q       <= '0;
         snap_q      <= '0;
         pot_q       <= '0;
         ts_q        <= '0;
         spike_q     <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         clear_dly_q <= clear;
         set_dly_q   <= set;
         acc_q       <= acc_d;
         spike_q     <= 1'b0;
         if (set_edge && state_q != S_ACCUM) overrun_q <= 1'b1;
         case (state_q)
            S_ACCUM: begin
               if (set_edge) begin
                  snap_q  <= acc_d;
                  state_q <= S_EVAL;
               end
            end
            S_EVAL: begin
               pot_q   <= sat(eval_sum);
               state_q <= S_EMIT;
            end
            S_EMIT: begin
               if (pot_q >= THRESH) begin
                  spike_q <= 1'b1;
                  pot_q   <= V_RESET;
               end
               ts_q    <= ts_q + 32'd1;
               state_q <= S_ACCUM;
            end
            default: state_q <= S_ACCUM;
         endcase
      end
   end

   assign spike_out = spike_q;
   assign potential = pot_q;
   assign timestep  = ts_q;
   assign overrun   = overrun_q;

endmodule
